// File: rtl/digit_conv_sched.sv
// ---------------------------------------------------------------------------
// digit_conv_sched
//
// Round-robin scheduler in front of a single sequential binary-to-BCD
// (double-dabble) engine. Three requesters share the engine:
//   0 = minutes, 1 = seconds, 2 = temperature.
// A granted value is converted in IN_W clock steps. The result is returned as
// hundreds/tens/ones BCD digits, tagged with the requester index.
//
// Build option:
//   DIGIT_SCHED_BLANK_EN - when defined, leading zeros are output as 4'hF.
//                          The ones digit is never blanked.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req[2:0]     level requests, held by each requester until its gnt bit
//   minutes[5:0] value for requester 0
//   seconds[5:0] value for requester 1
//   temp[8:0]    value for requester 2
//   gnt[2:0]     one-hot grant, one cycle wide
//   busy         conversion in progress
//   done         one-cycle pulse; the digit outputs are valid in that cycle
//   done_id[1:0] requester index of the finished conversion
//   dig_hundred/dig_ten/dig_ones[3:0]  BCD result, held until the next done
// ---------------------------------------------------------------------------
module digit_conv_sched #(
    parameter int IN_W = 9,
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [5:0]      minutes,
    input  logic [5:0]      seconds,
    input  logic [8:0]      temp,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            done,
    output logic [1:0]      done_id,
    output logic [3:0]      dig_hundred,
    output logic [3:0]      dig_ten,
    output logic [3:0]      dig_ones
);

    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [IN_W-1:0]   shreg_q, shreg_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        id_q, id_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              done_q, done_d;
    logic [1:0]        done_id_q, done_id_d;
    logic [3:0]        hund_q, hund_d;
    logic [3:0]        ten_q, ten_d;
    logic [3:0]        ones_q, ones_d;

    // Round-robin arbiter: search starts just after the last granted index.
    logic              win_valid;
    logic [1:0]        win_idx;
    logic [IN_W-1:0]   win_val;

    always_comb begin
        logic [1:0] cand;
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 2'((int'(ptr_q) + i) % NREQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        case (win_idx)
            2'd0:    win_val = IN_W'(minutes);
            2'd1:    win_val = IN_W'(seconds);
            default: win_val = IN_W'(temp);
        endcase
    end

    // One double-dabble step: correct each nibble, then shift {bcd, shreg}.
    logic [11:0]     bcd_adj;
    logic [11:0]     bcd_sh;
    logic [IN_W-1:0] shreg_sh;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dd_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 :
                                        bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign bcd_sh   = {bcd_adj[10:0], shreg_q[IN_W-1]};
    assign shreg_sh = {shreg_q[IN_W-2:0], 1'b0};

    // Final digit formatting, applied as the result is registered.
    logic [3:0] hund_fmt, ten_fmt;

`ifdef DIGIT_SCHED_BLANK_EN
    always_comb begin
        hund_fmt = (bcd_sh[11:8] == 4'd0) ? 4'hF : bcd_sh[11:8];
        ten_fmt  = (bcd_sh[11:8] == 4'd0 && bcd_sh[7:4] == 4'd0) ? 4'hF : bcd_sh[7:4];
    end
`else
    always_comb begin
        hund_fmt = bcd_sh[11:8];
        ten_fmt  = bcd_sh[7:4];
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd2;
            shreg_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            id_q      <= 2'd0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= 2'd0;
            hund_q    <= 4'd0;
            ten_q     <= 4'd0;
            ones_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            shreg_q   <= shreg_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            hund_q    <= hund_d;
            ten_q     <= ten_d;
            ones_q    <= ones_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        shreg_d   = shreg_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        hund_d    = hund_q;
        ten_d     = ten_q;
        ones_d    = ones_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = CONV;
                    ptr_d   = win_idx;
                    shreg_d = win_val;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    id_d    = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                end
            end
            CONV: begin
                shreg_d = shreg_sh;
                bcd_d   = bcd_sh;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    hund_d    = hund_fmt;
                    ten_d     = ten_fmt;
                    ones_d    = bcd_sh[3:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        gnt         = gnt_q;
        busy        = (state_q == CONV);
        done        = done_q;
        done_id     = done_id_q;
        dig_hundred = hund_q;
        dig_ten     = ten_q;
        dig_ones    = ones_q;
    end

endmodule

// File: tb/tb_digit_conv_sched.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for digit_conv_sched. Expected digits are
// hand-computed; B is the code a leading zero takes in the current build.
// ---------------------------------------------------------------------------
module tb_digit_conv_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [5:0] minutes, seconds;
    logic [8:0] temp;
    logic [2:0] gnt;
    logic       busy, done;
    logic [1:0] done_id;
    logic [3:0] dig_hundred, dig_ten, dig_ones;

    int checks   = 0;
    int failures = 0;

`ifdef DIGIT_SCHED_BLANK_EN
    localparam logic [3:0] B = 4'hF;
`else
    localparam logic [3:0] B = 4'h0;
`endif

    digit_conv_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .minutes     (minutes),
        .seconds     (seconds),
        .temp        (temp),
        .gnt         (gnt),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id),
        .dig_hundred (dig_hundred),
        .dig_ten     (dig_ten),
        .dig_ones    (dig_ones)
    );

    always #5 clk = ~clk;

    // Waits for a grant, optionally drops the granted req bit, sets temp to
    // temp_after, then waits for done. Observations only; callers compare.
    // gw: negedges until gnt seen; dw: negedges from gnt to done;
    // glen: extra cycles gnt stayed non-zero.
    task automatic observe(input bit drop, input logic [8:0] temp_after,
                           output logic [2:0] g, output int gw, output int dw,
                           output int glen, output logic [1:0] id,
                           output logic [11:0] digs);
        gw = 0; dw = 0; glen = 0;
        do begin @(negedge clk); gw++; end while (gnt == 3'b000 && gw < 40);
        g = gnt;
        if (drop) req = req & ~gnt;
        temp = temp_after;
        do begin
            @(negedge clk); dw++;
            if (gnt != 3'b000) glen++;
        end while (done !== 1'b1 && dw < 40);
        id   = done_id;
        digs = {dig_hundred, dig_ten, dig_ones};
        $display("xact: gnt=%b wait=%0d done_after=%0d id=%0d digits=%h/%h/%h",
                 g, gw, dw, id, digs[11:8], digs[7:4], digs[3:0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 3'b000; minutes = 0; seconds = 0; temp = 0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (done_id !== 2'd0) begin failures++; $display("FAIL reset_done_id: got %0d expected 0", done_id); end
        checks++; if ({dig_hundred, dig_ten, dig_ones} !== 12'h000) begin failures++;
            $display("FAIL reset_digits: got %h expected 000", {dig_hundred, dig_ten, dig_ones}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_temp();
        logic [2:0] g; int gw, dw, glen; logic [1:0] id; logic [11:0] d;
        temp = 9'd375; req = 3'b100;
        observe(1'b1, 9'd375, g, gw, dw, glen, id, d);
        checks++; if (g !== 3'b100) begin failures++; $display("FAIL single_gnt: got %b expected 100", g); end
        checks++; if (gw !== 1) begin failures++; $display("FAIL single_gnt_latency: got %0d expected 1", gw); end
        checks++; if (glen !== 0) begin failures++; $display("FAIL single_gnt_width: got %0d extra cycles expected 0", glen); end
        checks++; if (dw !== 9) begin failures++; $display("FAIL single_done_latency: got %0d expected 9", dw); end
        checks++; if (id !== 2'd2) begin failures++; $display("FAIL single_done_id: got %0d expected 2", id); end
        checks++; if (d !== 12'h375) begin failures++; $display("FAIL single_digits: got %h expected 375", d); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_width: got %b expected 0", done); end
        checks++; if ({dig_hundred, dig_ten, dig_ones} !== 12'h375) begin failures++;
            $display("FAIL single_digits_hold: got %h expected 375", {dig_hundred, dig_ten, dig_ones}); end
    endtask

    task automatic test_round_robin();
        logic [2:0] g; int gw, dw, glen; logic [1:0] id; logic [11:0] d;
        logic [2:0]  exp_g [3] = '{3'b001, 3'b010, 3'b100};
        logic [11:0] exp_d [3] = '{{B, 4'd5, 4'd9}, {B, B, 4'd7}, 12'h511};
        minutes = 6'd59; seconds = 6'd7; temp = 9'd511; req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            observe(1'b1, 9'd511, g, gw, dw, glen, id, d);
            checks++; if (g !== exp_g[i]) begin failures++; $display("FAIL rr_gnt%0d: got %b expected %b", i, g, exp_g[i]); end
            checks++; if (gw !== 1) begin failures++; $display("FAIL rr_spacing%0d: got %0d expected 1", i, gw); end
            checks++; if (dw !== 9) begin failures++; $display("FAIL rr_latency%0d: got %0d expected 9", i, dw); end
            checks++; if (id !== 2'(i)) begin failures++; $display("FAIL rr_id%0d: got %0d expected %0d", i, id, i); end
            checks++; if (d !== exp_d[i]) begin failures++; $display("FAIL rr_digits%0d: got %h expected %h", i, d, exp_d[i]); end
        end
    endtask

    task automatic test_fairness();
        logic [2:0] g; int gw, dw, glen; logic [1:0] id; logic [11:0] d;
        logic [2:0] exp_g [3] = '{3'b001, 3'b010, 3'b001};
        req = 3'b010;
        observe(1'b0, temp, g, gw, dw, glen, id, d);
        checks++; if (g !== 3'b010) begin failures++; $display("FAIL fair_setup: got %b expected 010", g); end
        req = 3'b011;
        for (int i = 0; i < 3; i++) begin
            observe(1'b0, temp, g, gw, dw, glen, id, d);
            checks++; if (g !== exp_g[i]) begin failures++; $display("FAIL fair_gnt%0d: got %b expected %b", i, g, exp_g[i]); end
        end
        req = 3'b000;
        checks++; if (d !== {B, 4'd5, 4'd9}) begin failures++; $display("FAIL fair_digits: got %h expected %h", d, {B, 4'd5, 4'd9}); end
    endtask

    task automatic test_reset_mid_conv();
        logic [2:0] g; int gw, dw, glen, n, ndone; logic [1:0] id; logic [11:0] d;
        @(negedge clk);
        req = 3'b001;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 3'b000 && n < 40);
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL midrst_gnt: got %b expected 001", gnt); end
        req = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL midrst_gnt_clear: got %b expected 000", gnt); end
        checks++; if ({dig_hundred, dig_ten, dig_ones} !== 12'h000) begin failures++;
            $display("FAIL midrst_digits: got %h expected 000", {dig_hundred, dig_ten, dig_ones}); end
        ndone = 0;
        repeat (2) begin @(negedge clk); if (done === 1'b1) ndone++; end
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (done === 1'b1) ndone++; end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d pulses expected 0", ndone); end
        req = 3'b011;
        observe(1'b1, temp, g, gw, dw, glen, id, d);
        req = 3'b000;
        checks++; if (g !== 3'b001) begin failures++; $display("FAIL midrst_priority: got %b expected 001", g); end
        checks++; if (d !== {B, 4'd5, 4'd9}) begin failures++; $display("FAIL midrst_digits_after: got %h expected %h", d, {B, 4'd5, 4'd9}); end
    endtask

    task automatic test_input_stability();
        logic [2:0] g; int gw, dw, glen; logic [1:0] id; logic [11:0] d;
        temp = 9'd0; req = 3'b100;
        observe(1'b1, 9'd100, g, gw, dw, glen, id, d);
        checks++; if (g !== 3'b100) begin failures++; $display("FAIL stab_gnt: got %b expected 100", g); end
        checks++; if (d !== {B, B, 4'd0}) begin failures++; $display("FAIL stab_digits: got %h expected %h", d, {B, B, 4'd0}); end
    endtask

    task automatic test_req_pulse();
        int n, ngnt, ndone;
        temp = 9'd375; req = 3'b100;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 3'b000 && n < 40);
        checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL pulse_gnt: got %b expected 100", gnt); end
        req = 3'b000;
        n = 0;
        @(negedge clk); n++;
        @(negedge clk); n++;
        req = 3'b010;
        @(negedge clk); n++;
        req = 3'b000;
        ngnt = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
            if (gnt != 3'b000) ngnt++;
        end
        $display("xact: pulse case done_after=%0d digits=%h/%h/%h", n, dig_hundred, dig_ten, dig_ones);
        checks++; if (n !== 9) begin failures++; $display("FAIL pulse_latency: got %0d expected 9", n); end
        checks++; if ({dig_hundred, dig_ten, dig_ones} !== 12'h375) begin failures++;
            $display("FAIL pulse_digits: got %h expected 375", {dig_hundred, dig_ten, dig_ones}); end
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (gnt != 3'b000) ngnt++;
            if (done === 1'b1) ndone++;
        end
        checks++; if (ngnt !== 0) begin failures++; $display("FAIL pulse_no_gnt: got %0d grants expected 0", ngnt); end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL pulse_no_done: got %0d pulses expected 0", ndone); end
    endtask

    initial begin
        test_reset();
        test_single_temp();
        test_round_robin();
        test_fairness();
        test_reset_mid_conv();
        test_input_stability();
        test_req_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_conv_sched.md
# digit_conv_sched

- Round-robin scheduler and sequential binary-to-BCD converter.
- Shares one double-dabble conversion engine between three requesters: minutes, seconds and temperature.
- Sits between the timer/temperature registers and the 7-segment display driver; returns hundreds/tens/ones digits tagged with the requester ID.

## Interface
Parameters:
- `IN_W`, 9: conversion width; all inputs are zero-extended to `IN_W`.
- `NREQ`, 3: number of requesters (fixed at 3: 0 = minutes, 1 = seconds, 2 = temperature).

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  level request per requester; the requester holds it until it sees its `gnt` bit.
- `minutes`  in  6  binary value for requester 0.
- `seconds`  in  6  binary value for requester 1.
- `temp`  in  9  binary value for requester 2.
- `gnt`  out  3  one-hot grant, high for exactly one cycle.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; the digit outputs are valid in that cycle.
- `done_id`  out  2  requester index of the finished conversion.
- `dig_hundred`, `dig_ten`, `dig_ones`  out  4 each  BCD result, held until the next `done`.

## Operation
- States: IDLE, CONV.
- IDLE, with no request: no action.
- IDLE, with any `req` bit high: at the edge,
  - the arbiter picks the winner;
  - the winner's value is loaded, zero-extended, into a shift register;
  - the BCD accumulator is cleared and the step counter is set to 0;
  - `gnt[winner]` is set to 1 and the winner's ID is latched;
  - the state moves to CONV.
- Arbitration is round-robin:
  - Search starts at the index after the last granted requester and wraps modulo 3.
  - After reset the last-granted pointer is 2, so the first priority order is 0, 1, 2.
  - The pointer updates on every grant.
- CONV, each edge performs one double-dabble step:
  - add 3 to each BCD nibble that is ≥ 5;
  - shift {bcd, shreg} left by 1;
  - increment the counter.
- CONV on step `IN_W` (counter = `IN_W`−1):
  - register the final digits into the `dig_*` outputs;
  - drive `done` = 1 and `done_id` = latched ID;
  - return to IDLE.
- Input values are sampled only at grant. Later changes on `minutes`/`seconds`/`temp` do not affect the conversion in flight.
- A `req` that drops before it is granted is not served. A `req` still high when the block returns to IDLE is served again, subject to round-robin order.
- Range:
  - Maximum input is 511, so `dig_hundred` ≤ 5.
  - Minutes and seconds always give `dig_hundred` = 0, before blanking.
- Reset values: `gnt` = 0, `busy` = 0, `done` = 0, `done_id` = 0, all `dig_*` = 0, state = IDLE, pointer = 2.
- Reset asserted mid-CONV: the conversion is abandoned immediately, no `done` is issued, and outputs take their reset values.

## Timing
- Grant edge k: `gnt` is high in cycle k+1 only. `busy` goes high at edge k.
- Conversion steps happen at edges k+1 … k+`IN_W` (k+9 for the default width).
- `done` and the new digits appear after edge k+9, for one cycle. `busy` falls at the same edge.
- The earliest next grant is edge k+10.
- Throughput is one conversion per 10 cycles. `gnt` to `done` is 9 cycles.
- Simultaneous requests are served back-to-back, one every 10 cycles, in round-robin order.

## Configuration
- `DIGIT_SCHED_BLANK_EN` defined: leading-zero blanking is on.
  - If `dig_hundred` = 0 it is output as 4'hF.
  - If both `dig_hundred` and `dig_ten` are 0, `dig_ten` is also output as 4'hF.
  - `dig_ones` is never blanked.
  - Blanking is applied when the outputs are registered; timing is unchanged.
- Not defined: raw BCD digits are output, including leading zeros.

## Test plan
- Reset, then `req` = 3'b100 with `temp` = 375 → `gnt` = 3'b100 for one cycle; 9 cycles later `done` = 1, `done_id` = 2, digits 3/7/5.
- `req` = 3'b111 held until each bit is granted, with `minutes` = 59, `seconds` = 7, `temp` = 511 → grants in order 0, 1, 2, 10 cycles apart. Results:
  - blanking off: 0/5/9, 0/0/7, 5/1/1;
  - blanking on: F/5/9, F/F/7, 5/1/1.
- Fairness: after a grant to requester 1, hold `req` = 3'b011 continuously → next grant goes to 0, then 1, then 0 (alternating).
- `temp` = 0 → digits 0/0/0, or F/F/0 with `DIGIT_SCHED_BLANK_EN`. Changing `temp` to 100 during CONV leaves the result 0/0/0.
- Assert `rst_n` = 0 at CONV step 4 → `busy`, `gnt` and digits go to 0 immediately, and no `done` pulse occurs. After release, a fresh request to 0 gets priority.
- `req` pulse of one cycle while `busy` → never granted, and no extra `done`.
